link_rx_buffer: RTL and testbench

- Receive-side buffer between an internode_link rx port and a crossbar_ext inject port; this is the counterpart of the eject/tx path.
- Captures flits whose valid bit (MSB) is set while rx_ready is high, and stores them in a synchronous FIFO.
- Presents stored flits to the switch with a valid/ready handshake.
- Drives the link-level slot-available flag back to the remote transmitter, with enough slack to cover round-trip flits already in flight.

---
 rtl/noc_link_pkg.sv | 35 +++
 rtl/link_fifo_mem.sv | 59 +++++
 rtl/link_rx_buffer.sv | 150 +++++++++++++++
 tb/tb_link_rx_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// ---------------------------------------------------------------------------
// noc_link_pkg
// Shared constants for the inter-node link datapath: flit field positions,
// default flit width and link delay, and a constant clog2 helper used to size
// pointers from FIFO depths.
// Ports: none (package).
// ---------------------------------------------------------------------------
package noc_link_pkg;

  localparam int DefaultDataWidth = 256;

  // Flit layout, MSB first: valid, priority, index, exit, reduction flag.
  localparam int VALID_BIT       = DefaultDataWidth - 1;
  localparam int PriorityPos     = VALID_BIT - 1;
  localparam int IndexPos        = PriorityPos - 8;
  localparam int ExitPos         = IndexPos - 8;
  localparam int ReductionBitPos = ExitPos - 8;

  // One-way link latency in cycles; the rx buffer reserves twice this as slack.
  localparam int DefaultLinkDelay = 20;

  // Ceiling log2 for sizing pointers at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/link_fifo_mem.sv
// ---------------------------------------------------------------------------
// link_fifo_mem
// Simple dual-port register array with a synchronous write port and a
// registered read port. The read register is the FWFT output stage of the
// rx buffer: it is addressed by the *next* read pointer, so the head flit is
// already sitting in it when the controller raises inject_valid.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears read register)
//   wr_en      write strobe
//   wr_addr    write address
//   wr_data    write data
//   rd_en      load the read register this cycle
//   rd_addr    read address (next head position)
//   rd_data    registered read data
// ---------------------------------------------------------------------------
module link_fifo_mem
  import noc_link_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth,
  parameter int Depth     = 128,
  parameter int PtrWidth  = clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [PtrWidth-1:0]  wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [PtrWidth-1:0]  rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem_r [Depth];
  logic [DataWidth-1:0] rd_data_r;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Output register; a same-cycle write to the head slot is forwarded so a
  // flit landing in an empty (or just-emptied) FIFO shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_r <= wr_data;
      end else begin
        rd_data_r <= mem_r[rd_addr];
      end
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/link_rx_buffer.sv
// ---------------------------------------------------------------------------
// link_rx_buffer
// Receive-side buffer between an internode_link rx port and a crossbar_ext
// inject port. Flits with their valid bit set are captured while the link
// receiver is ready, queued in a FWFT FIFO and offered to the switch with a
// valid/ready handshake. slot_avail tells the remote transmitter it may keep
// sending, withdrawn early enough that flits already in flight still fit.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rx_par_data   parallel flit from the link, MSB = valid
//   rx_ready      link receiver locked; input ignored while low
//   slot_avail    remote may send (to peer tx_ready)
//   inject_data   head flit towards the switch
//   inject_valid  head flit present
//   inject_ready  switch takes the head flit this cycle
//   occupancy     current number of stored flits
//   drop_pulse    one-cycle pulse after an arriving flit was discarded
//   drop_cnt      saturating count of discarded flits
// ---------------------------------------------------------------------------
module link_rx_buffer
  import noc_link_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth,
  parameter int Depth     = 128,
  parameter int Slack     = 2 * DefaultLinkDelay,
  parameter int PtrWidth  = clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] rx_par_data,
  input  logic                 rx_ready,
  output logic                 slot_avail,
  output logic [DataWidth-1:0] inject_data,
  output logic                 inject_valid,
  input  logic                 inject_ready,
  output logic [PtrWidth:0]    occupancy,
  output logic                 drop_pulse,
  output logic [7:0]           drop_cnt
);

  localparam logic [PtrWidth:0] DepthCnt  = (PtrWidth + 1)'(Depth);
  localparam logic [PtrWidth:0] SlotLimit = (PtrWidth + 1)'(Depth - Slack - 1);

  logic [PtrWidth-1:0] wr_ptr_r;
  logic [PtrWidth-1:0] rd_ptr_r;
  logic [PtrWidth-1:0] rd_ptr_next_s;
  logic [PtrWidth:0]   occ_r;
  logic [PtrWidth:0]   occ_next_s;
  logic                inject_valid_r;
  logic                slot_avail_r;
  logic                drop_pulse_r;
  logic [7:0]          drop_cnt_r;

  logic push_req_s;
  logic pop_s;
  logic full_s;
  logic push_acc_s;
  logic drop_s;
  logic wr_en_s;
  logic rd_en_s;

  // Handshake qualification, accept/drop decision and next occupancy.
  always_comb begin
    push_req_s    = rx_par_data[DataWidth-1] & rx_ready;
    pop_s         = inject_valid_r & inject_ready;
    full_s        = (occ_r == DepthCnt);
    push_acc_s    = 1'b0;
    drop_s        = 1'b0;
    occ_next_s    = occ_r;
    rd_ptr_next_s = rd_ptr_r;

    // A full FIFO still takes a flit when the head leaves in the same cycle.
    if (push_req_s && (!full_s || pop_s)) begin
      push_acc_s = 1'b1;
    end else begin
      push_acc_s = 1'b0;
    end

    if (push_req_s && full_s && !pop_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end

    case ({push_acc_s, pop_s})
      2'b10:   occ_next_s = occ_r + (PtrWidth + 1)'(1);
      2'b01:   occ_next_s = occ_r - (PtrWidth + 1)'(1);
      default: occ_next_s = occ_r;
    endcase

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PtrWidth'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
  end

  // Writes are suppressed during reset so a reset cycle never leaves a flit
  // behind; the read register only reloads while something will be stored.
  assign wr_en_s = push_acc_s & ~rst;
  assign rd_en_s = (occ_next_s != '0);

  // Pointers, occupancy, head-valid, flow-control flag and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      occ_r          <= '0;
      inject_valid_r <= 1'b0;
      slot_avail_r   <= 1'b0;
      drop_pulse_r   <= 1'b0;
      drop_cnt_r     <= 8'd0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PtrWidth'(1);
      end
      rd_ptr_r       <= rd_ptr_next_s;
      occ_r          <= occ_next_s;
      inject_valid_r <= (occ_next_s != '0);
      // Withdrawn at Depth-Slack so a full round trip of flits still fits.
      slot_avail_r   <= (occ_next_s <= SlotLimit);
      drop_pulse_r   <= drop_s;
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  link_fifo_mem #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .PtrWidth  (PtrWidth)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (rx_par_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_ptr_next_s),
    .rd_data (inject_data)
  );

  assign inject_valid = inject_valid_r;
  assign slot_avail   = slot_avail_r;
  assign occupancy    = occ_r;
  assign drop_pulse   = drop_pulse_r;
  assign drop_cnt     = drop_cnt_r;

endmodule

// File: tb/tb_link_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_link_rx_buffer
// Self-checking bench for link_rx_buffer: a reset/single-flit vector table,
// hand-written fill/overflow/drain/wrap/reset sequences and a randomized
// phase, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_link_rx_buffer;

  localparam int DW    = 256;
  localparam int DEPTH = 128;
  localparam int SLACK = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   rx_par_data;
  logic            rx_ready;
  logic            slot_avail;
  logic [DW-1:0]   inject_data;
  logic            inject_valid;
  logic            inject_ready;
  logic [7:0]      occupancy;
  logic            drop_pulse;
  logic [7:0]      drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  int            m_cnt   = 0;
  logic          m_pulse = 1'b0;
  logic          m_slot  = 1'b0;

  always #5 clk = ~clk;

  link_rx_buffer #(
    .DataWidth (DW),
    .Depth     (DEPTH),
    .Slack     (SLACK),
    .PtrWidth  (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_par_data  (rx_par_data),
    .rx_ready     (rx_ready),
    .slot_avail   (slot_avail),
    .inject_data  (inject_data),
    .inject_valid (inject_valid),
    .inject_ready (inject_ready),
    .occupancy    (occupancy),
    .drop_pulse   (drop_pulse),
    .drop_cnt     (drop_cnt)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit(input logic v, input int payload);
    logic [DW-1:0] f;
    f = {v, 255'(payload)};
    return f;
  endfunction

  // Compare DUT outputs against the model's current view of the buffer.
  task automatic compare_model();
    chk("m_occupancy", {248'd0, occupancy}, q.size());
    chk("m_valid", {255'd0, inject_valid}, {255'd0, (q.size() != 0)});
    if (q.size() != 0) chk("m_data", inject_data, q[0]);
    chk("m_slot", {255'd0, slot_avail}, {255'd0, m_slot});
    chk("m_drop_pulse", {255'd0, drop_pulse}, {255'd0, m_pulse});
    chk("m_drop_cnt", {248'd0, drop_cnt}, m_cnt);
  endtask

  // Drive one cycle of inputs, advance the model by the buffer's rules,
  // then sample the DUT just after the clock edge.
  task automatic tick(input logic r, input logic [DW-1:0] d, input logic rdy, input logic ir);
    bit pop, push, drop;
    rst = r; rx_par_data = d; rx_ready = rdy; inject_ready = ir;
    if (r) begin
      q.delete(); m_cnt = 0; m_pulse = 1'b0; m_slot = 1'b0;
    end else begin
      pop  = (q.size() != 0) && ir;
      push = d[DW-1] && rdy;
      drop = push && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(d);
      m_pulse = drop;
      if (drop && m_cnt < 255) m_cnt++;
      m_slot = (q.size() <= DEPTH - SLACK - 1);
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic          rst;
    logic [DW-1:0] data;
    logic          rdy;
    logic          ir;
    logic          exp_valid;
    logic          chk_data;
    logic [DW-1:0] exp_data;
    int            exp_occ;
    logic          exp_slot;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [DW-1:0] fa5;
    logic [DW-1:0] rnd;
    int seq;
    int ir_pct;

    rst = 1'b1; rx_par_data = '0; rx_ready = 1'b0; inject_ready = 1'b0;
    fa5 = flit(1'b1, 32'h0A5);

    // ---------------- vector table: reset, single flit, gating ----------
    vecs.push_back('{1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 0, 1'b0});
    vecs.push_back('{1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 0, 1'b0});
    for (int i = 1; i <= 9; i++)
      vecs.push_back('{1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 1'b1});
    vecs.push_back('{1'b0, fa5, 1'b1, 1'b1, 1'b1, 1'b1, fa5, 1, 1'b1});
    vecs.push_back('{1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 1'b1});
    vecs.push_back('{1'b0, flit(1'b0, 32'h5A), 1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 1'b1});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, fa5, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].data, vecs[i].rdy, vecs[i].ir);
      chk("vec_valid", {255'd0, inject_valid}, {255'd0, vecs[i].exp_valid});
      chk("vec_occ", {248'd0, occupancy}, vecs[i].exp_occ);
      chk("vec_slot", {255'd0, slot_avail}, {255'd0, vecs[i].exp_slot});
      if (vecs[i].chk_data) chk("vec_data", inject_data, vecs[i].exp_data);
    end

    // ---------------- backpressure and slack ---------------------------
    for (int i = 1; i <= DEPTH; i++) begin
      tick(1'b0, flit(1'b1, i), 1'b1, 1'b0);
      if (i == 87) chk("slot_at_87", {255'd0, slot_avail}, {255'd0, 1'b1});
      if (i == 88) chk("slot_at_88", {255'd0, slot_avail}, {255'd0, 1'b0});
    end
    chk("fill_occ", {248'd0, occupancy}, 128);
    chk("fill_drops", {248'd0, drop_cnt}, 0);

    // ---------------- overflow -----------------------------------------
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, flit(1'b1, 500 + i), 1'b1, 1'b0);
      chk("ovf_pulse", {255'd0, drop_pulse}, {255'd0, 1'b1});
    end
    chk("ovf_cnt", {248'd0, drop_cnt}, 3);
    chk("ovf_head", inject_data, flit(1'b1, 1));
    tick(1'b0, '0, 1'b1, 1'b0);

    // ---------------- drain in order, no bubbles -----------------------
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_valid", {255'd0, inject_valid}, {255'd0, 1'b1});
      chk("drain_data", inject_data, flit(1'b1, i));
      tick(1'b0, '0, 1'b1, 1'b1);
    end
    chk("drain_occ", {248'd0, occupancy}, 0);

    // ---------------- full with simultaneous push and pop --------------
    for (int i = 1; i <= DEPTH; i++) tick(1'b0, flit(1'b1, 2000 + i), 1'b1, 1'b0);
    tick(1'b0, flit(1'b1, 3000), 1'b1, 1'b1);
    chk("fullpp_occ", {248'd0, occupancy}, 128);
    chk("fullpp_cnt", {248'd0, drop_cnt}, 3);
    chk("fullpp_pulse", {255'd0, drop_pulse}, {255'd0, 1'b0});
    for (int i = 0; i < DEPTH + 1; i++) tick(1'b0, '0, 1'b1, 1'b1);
    chk("fullpp_empty", {248'd0, occupancy}, 0);

    // ---------------- gating and pointer wrap --------------------------
    for (int i = 0; i < 5; i++) tick(1'b0, flit(1'b1, 77), 1'b0, 1'b1);
    chk("gate_occ", {248'd0, occupancy}, 0);
    seq = 1;
    for (int i = 1; i <= 300; i++) begin
      if (inject_valid) begin
        chk("stream_order", inject_data, flit(1'b1, 4000 + seq));
        seq++;
      end
      tick(1'b0, flit(1'b1, 4000 + i), 1'b1, 1'b1);
      if (i % 50 == 0) begin
        if (inject_valid) begin
          chk("stream_order", inject_data, flit(1'b1, 4000 + seq));
          seq++;
        end
        tick(1'b0, flit(1'b0, 9999), 1'b1, 1'b1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (inject_valid) begin
        chk("stream_order", inject_data, flit(1'b1, 4000 + seq));
        seq++;
      end
      tick(1'b0, '0, 1'b1, 1'b1);
    end
    chk("stream_count", 256'(seq - 1), 300);

    // ---------------- reset mid-stream ---------------------------------
    for (int i = 1; i <= 50; i++) tick(1'b0, flit(1'b1, 6000 + i), 1'b1, 1'b0);
    chk("pre_rst_occ", {248'd0, occupancy}, 50);
    tick(1'b1, flit(1'b1, 7000), 1'b1, 1'b1);
    chk("rst_valid", {255'd0, inject_valid}, {255'd0, 1'b0});
    chk("rst_occ", {248'd0, occupancy}, 0);
    chk("rst_cnt", {248'd0, drop_cnt}, 0);
    chk("rst_slot", {255'd0, slot_avail}, {255'd0, 1'b0});
    chk("rst_data", inject_data, '0);
    tick(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_slot", {255'd0, slot_avail}, {255'd0, 1'b1});

    // ---------------- randomized phase ---------------------------------
    for (int blk = 0; blk < 15; blk++) begin
      ir_pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 200; c++) begin
        for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom;
        rnd[DW-1] = ($urandom_range(99) < 80);
        tick(($urandom_range(999) == 0), rnd, ($urandom_range(99) < 90),
             ($urandom_range(99) < ir_pct));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
